// File: rtl/mips_cpu_sequencer.sv
// Multicycle state sequencer for the MIPS-compatible CPU.
// Produces the state code consumed by mips_cpu_controller (0 halt, 1 fetch,
// 2 decode, 2+k exec stage k), with per-instruction exec length, Avalon
// waitrequest stalls, a HI/LO interlock and halt-on-jump-to-zero.
module mips_cpu_sequencer #(
   parameter int unsigned MAX_EXEC    = 2,
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned STATE_W     = $clog2(MAX_EXEC + 3),
   parameter int unsigned LEN_W       = $clog2(MAX_EXEC + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               waitrequest,
   input  logic               mem_access,
   input  logic [LEN_W-1:0]   exec_len,
   input  logic               hilo_read,
   input  logic               muldiv_start,
   input  logic               muldiv_is_div,
   input  logic               pc_next_zero,
   output logic [STATE_W-1:0] state,
   output logic               active,
   output logic               stall,
   output logic               muldiv_busy,
   output logic               instr_done
);

   localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_EXEC1  = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_LAST   = STATE_W'(MAX_EXEC + 2);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_EXEC);

   localparam int unsigned CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

   logic [STATE_W-1:0] state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               hilo_q, hilo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               in_exec;
   logic               last_stage;
   logic               exec_first;
   logic [STATE_W-1:0] exec_idx;
   logic [LEN_W-1:0]   len_clamped;

   // Stage classification and the combinational stall / retire outputs.
   always_comb begin
      in_exec     = (state_q >= S_EXEC1) && (state_q <= S_LAST);
      exec_idx    = state_q - S_DECODE;
      exec_first  = in_exec && (state_q == S_EXEC1);
      last_stage  = in_exec && (exec_idx >= STATE_W'(len_q));
      muldiv_busy = (cnt_q != '0);
      stall       = 1'b0;
      if (state_q == S_FETCH) begin
         stall = waitrequest;
      end else if (in_exec) begin
         stall = (mem_access && waitrequest) || (exec_first && hilo_q && muldiv_busy);
      end
      instr_done = last_stage && !stall;
      active     = (state_q != S_HALT);
      state      = state_q;
   end

   // Clamp the decoded exec length into 1..MAX_EXEC.
   always_comb begin
      len_clamped = exec_len;
      if (exec_len == '0) begin
         len_clamped = LEN_ONE;
      end else if (exec_len > LEN_MAX) begin
         len_clamped = LEN_MAX;
      end
   end

   // Next-state selection; illegal codes fall into HALT.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      hilo_d  = hilo_q;
      if (state_q == S_HALT) begin
         state_d = S_HALT;
      end else if (state_q == S_FETCH) begin
         if (!stall) begin
            state_d = S_DECODE;
         end
      end else if (state_q == S_DECODE) begin
         state_d = S_EXEC1;
         len_d   = len_clamped;
         hilo_d  = hilo_read;
      end else if (in_exec) begin
         if (!stall) begin
            if (last_stage) begin
               state_d = pc_next_zero ? S_HALT : S_FETCH;
            end else begin
               state_d = state_q + STATE_W'(1);
            end
         end
      end else begin
         state_d = S_HALT;
      end
   end

   // Mul/div busy counter: a start (exec stages only) reloads, else count down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (muldiv_start && in_exec) begin
         cnt_d = muldiv_is_div ? CNT_DIV : CNT_MULT;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         len_q   <= LEN_ONE;
         hilo_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         hilo_q  <= hilo_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Self-checking bench for mips_cpu_sequencer: two builds (MAX_EXEC=2 and 4)
// driven by shared stimulus, compared every cycle against an instruction-level
// reference model (stage index within instruction, busy tracked as a deadline).
module tb_mips_cpu_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n = 1'b1;
   logic       waitrequest = 1'b0;
   logic       mem_access = 1'b0;
   logic [2:0] exec_len = 3'd1;
   logic       hilo_read = 1'b0;
   logic       muldiv_start = 1'b0;
   logic       muldiv_is_div = 1'b0;
   logic       pc_next_zero = 1'b0;

   logic [5:0] act_state;
   logic [1:0] act_active, act_stall, act_busy, act_done;

   mips_cpu_sequencer #(.MAX_EXEC(2), .MULT_CYCLES(4), .DIV_CYCLES(32)) u_seq2 (
      .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .mem_access(mem_access),
      .exec_len(exec_len[1:0]), .hilo_read(hilo_read), .muldiv_start(muldiv_start),
      .muldiv_is_div(muldiv_is_div), .pc_next_zero(pc_next_zero),
      .state(act_state[2:0]), .active(act_active[0]), .stall(act_stall[0]),
      .muldiv_busy(act_busy[0]), .instr_done(act_done[0])
   );

   mips_cpu_sequencer #(.MAX_EXEC(4), .MULT_CYCLES(4), .DIV_CYCLES(32)) u_seq4 (
      .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .mem_access(mem_access),
      .exec_len(exec_len), .hilo_read(hilo_read), .muldiv_start(muldiv_start),
      .muldiv_is_div(muldiv_is_div), .pc_next_zero(pc_next_zero),
      .state(act_state[5:3]), .active(act_active[1]), .stall(act_stall[1]),
      .muldiv_busy(act_busy[1]), .instr_done(act_done[1])
   );

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Reference model, one slot per build.
   int me[2] = '{2, 4};
   bit m_halt[2];
   int m_stage[2];      // 0 fetch, 1 decode, n>=2 is exec stage n-1
   int m_len[2];
   bit m_hilo[2];
   int m_busy_until[2]; // busy while cyc < this

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_halt[i]       = 1'b0;
         m_stage[i]      = 0;
         m_len[i]        = 1;
         m_hilo[i]       = 1'b0;
         m_busy_until[i] = 0;
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs, advance the model.
   task automatic step(input bit rst, input bit wr, input bit mem, input logic [2:0] len,
                       input bit hilo, input bit st, input bit isdiv, input bit pcz);
      int  l, k, exp_state;
      bit  ex, busy, stl, done;
      @(negedge clk);
      reset_n       = !rst;
      waitrequest   = wr;
      mem_access    = mem;
      exec_len      = len;
      hilo_read     = hilo;
      muldiv_start  = st;
      muldiv_is_div = isdiv;
      pc_next_zero  = pcz;
      if (rst) model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         busy = (cyc < m_busy_until[i]);
         ex   = !m_halt[i] && (m_stage[i] >= 2);
         k    = m_stage[i] - 1;
         stl  = !m_halt[i] && ((m_stage[i] == 0 && wr) ||
                (ex && ((mem && wr) || (k == 1 && m_hilo[i] && busy))));
         done = ex && !stl && (k == m_len[i]);
         exp_state = m_halt[i] ? 0 : m_stage[i] + 1;

         check_eq($sformatf("state_me%0d", me[i]), 32'(act_state[i*3 +: 3]), 32'(exp_state));
         check_eq($sformatf("active_me%0d", me[i]), 32'(act_active[i]), 32'(!m_halt[i]));
         check_eq($sformatf("stall_me%0d", me[i]), 32'(act_stall[i]), 32'(stl));
         check_eq($sformatf("busy_me%0d", me[i]), 32'(act_busy[i]), 32'(busy));
         check_eq($sformatf("done_me%0d", me[i]), 32'(act_done[i]), 32'(done));

         if (!rst) begin
            if (ex && st) m_busy_until[i] = cyc + 1 + (isdiv ? 32 : 4);
            if (!m_halt[i]) begin
               if (m_stage[i] == 0) begin
                  if (!stl) m_stage[i] = 1;
               end else if (m_stage[i] == 1) begin
                  l = (i == 0) ? int'(len[1:0]) : int'(len);
                  if (l == 0) l = 1;
                  if (l > me[i]) l = me[i];
                  m_len[i]   = l;
                  m_hilo[i]  = hilo;
                  m_stage[i] = 2;
               end else if (!stl) begin
                  if (k < m_len[i]) begin
                     m_stage[i] = m_stage[i] + 1;
                  end else begin
                     m_stage[i] = 0;
                     m_halt[i]  = pcz;
                  end
               end
            end
         end
      end
      cyc++;
   endtask

   initial begin
      int hc;
      model_reset();
      // reset
      step(1, 0, 0, 3'd1, 0, 0, 0, 0);
      step(1, 1, 0, 3'd1, 0, 0, 0, 0);
      // ADDU: fetch, decode, exec1
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      // LW, len 2, three waitrequest cycles in EXEC1
      step(0, 0, 0, 3'd2, 0, 0, 0, 0);
      step(0, 0, 0, 3'd2, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 3'd2, 0, 0, 0, 0);
      step(0, 0, 1, 3'd2, 0, 0, 0, 0);
      step(0, 0, 0, 3'd2, 0, 0, 0, 0);
      // DIV then MFLO
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 0, 1, 1, 0);
      step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 1, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      // MULT, restarted two cycles later while held in EXEC1
      step(0, 0, 0, 3'd2, 0, 0, 0, 0);
      step(0, 0, 0, 3'd2, 0, 0, 0, 0);
      step(0, 1, 1, 3'd2, 0, 1, 0, 0);
      step(0, 1, 1, 3'd2, 0, 0, 0, 0);
      step(0, 0, 0, 3'd2, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      // JR to zero, then toggle inputs while halted
      for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd1, 0, 0, 0, 0);
      step(0, 0, 0, 3'd1, 0, 0, 0, 1);
      step(0, 0, 0, 3'd1, 0, 0, 0, 1);
      step(0, 0, 0, 3'd1, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++)
         step(0, 1'($urandom % 2), 1'($urandom % 2), 3'd1, 0, 1'($urandom % 2), 1'($urandom % 2), 0);
      step(1, 0, 0, 3'd1, 0, 0, 0, 0);
      // Long clamped instructions and DIV in a deep exec stage, then reset mid-divide
      step(0, 0, 0, 3'd7, 0, 0, 0, 0);
      step(0, 0, 0, 3'd7, 0, 0, 0, 0);
      step(0, 0, 0, 3'd7, 0, 0, 0, 0);
      step(0, 0, 0, 3'd7, 0, 1, 1, 0);
      step(0, 0, 0, 3'd7, 0, 0, 0, 0);
      step(1, 0, 0, 3'd0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 3'd0, 0, 0, 0, 0);

      // Randomized traffic
      hc = 0;
      for (int n = 0; n < 4000; n++) begin
         bit rst;
         if (m_halt[0] || m_halt[1]) hc++;
         rst = (hc > 25) || ($urandom % 300 == 0);
         if (rst) hc = 0;
         step(rst, ($urandom % 4 == 0), 1'($urandom % 2), 3'($urandom % 8),
              ($urandom % 3 == 0), ($urandom % 8 == 0), ($urandom % 3 == 0),
              ($urandom % 20 == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_cpu_sequencer.md
# mips_cpu_sequencer

Parametrised multicycle state sequencer for the MIPS-compatible CPU. It drives the `state` code consumed by `mips_cpu_controller` (0 halted, 1 fetch, 2 decode, 3+ exec stages). It generalises the fixed two-exec-stage flow to a per-instruction exec length of up to `MAX_EXEC` stages. It also adds Avalon `waitrequest` stalls on any memory-accessing stage, a HI/LO interlock driven by a multi-cycle mul/div busy counter, and halt-on-jump-to-zero.

## Interface
- `MAX_EXEC`, 2, maximum exec stages per instruction (≥1); exec stage k encodes as state 2+k
- `MULT_CYCLES`, 4, busy cycles after a MULT/MULTU/MTHI/MTLO start
- `DIV_CYCLES`, 32, busy cycles after a DIV/DIVU start
- `STATE_W`, derived `$clog2(MAX_EXEC+3)`, state width
- `LEN_W`, derived `$clog2(MAX_EXEC+1)`, exec_len width
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `waitrequest`  in  1  Avalon slave stall
- `mem_access`  in  1  current stage issues memread/memwrite (from controller)
- `exec_len`  in  LEN_W  exec stages needed by the decoded instruction; sampled in DECODE
- `hilo_read`  in  1  decoded instruction is MFHI/MFLO; sampled in DECODE
- `muldiv_start`  in  1  HI/LO write launched this cycle (valid in exec stages only)
- `muldiv_is_div`  in  1  qualifies `muldiv_start`: 1 selects DIV_CYCLES
- `pc_next_zero`  in  1  next PC equals 0x00000000 (evaluated in the final exec stage)
- `state`  out  STATE_W  current state code
- `active`  out  1  high unless HALT
- `stall`  out  1  state is holding this cycle; the datapath gates regwrite, pcwrite and irwrite with `!stall`
- `muldiv_busy`  out  1  HI/LO result not yet valid
- `instr_done`  out  1  one-cycle pulse in the final exec stage of a retiring instruction

## Operation
- Registers: `state`, `len_q` (LEN_W), `hilo_q`, `busy_cnt` (width for DIV_CYCLES).
- Length clamping: `exec_len` 0 is treated as 1; values above MAX_EXEC are treated as MAX_EXEC.
- FETCH (1):
  - Hold while `waitrequest` (`stall`=1).
  - Otherwise go to DECODE.
- DECODE (2):
  - Latch `len_q` and `hilo_q`.
  - Always go to EXEC1 after one cycle.
- EXECk (2+k):
  - Hold with `stall`=1 if `mem_access && waitrequest`.
  - Hold with `stall`=1 if k==1 && `hilo_q` && `muldiv_busy`.
  - Otherwise, if k<len_q, go to EXECk+1.
  - Otherwise pulse `instr_done`, then go to HALT if `pc_next_zero`, else to FETCH.
- HALT (0): absorbing state; left only by reset. `active`=0.
- Illegal state codes (> MAX_EXEC+2) go to HALT on the next edge.
- Mul/div counter:
  - `muldiv_start` loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise the counter decrements while non-zero.
  - `muldiv_busy` = (busy_cnt != 0).
  - `muldiv_start` while busy restarts the count; start wins over decrement.
  - `muldiv_start` is ignored in FETCH, DECODE and HALT.
- `stall` and `instr_done` are combinational from the registered state and the inputs. `instr_done`=0 whenever `stall`=1.

## Timing
- Reset (async assert, sync-safe deassert): state=FETCH(1), active=1, stall=0 (waitrequest permitting), muldiv_busy=0, instr_done=0, len_q=1, hilo_q=0, busy_cnt=0.
- Reset mid-instruction or mid-divide: all of the above take effect immediately; no pending busy survives.
- Minimum instruction latency: 2+len_q cycles, plus one cycle per stalled cycle.
- Counter: start at edge t → `muldiv_busy` high for exactly N cycles after t, low from t+N.
- MFHI issued immediately after DIV: EXEC1 holds until the first cycle `muldiv_busy`=0, then advances on that edge.
- `waitrequest` and the HI/LO interlock active together: one combined hold; advance only when both clear.
- `pc_next_zero` is ignored outside the final exec stage and while stalled.

## Test plan
- Reset, then a 1-exec instruction (ADDU) with no waits → states 1,2,3,1; `instr_done` high exactly in cycle 3.
- LW with len=2 and `waitrequest` high for 3 cycles in EXEC1 → state 3 held 3 cycles with `stall`=1, then 4, then 1; 7 cycles total.
- DIV (start in EXEC1, DIV_CYCLES=32) followed by MFLO → MFLO EXEC1 stalls until busy falls 32 cycles after start; one write-enable cycle with `stall`=0.
- MULT started, then a second MULT started 2 cycles later → busy extends to 4 cycles after the second start.
- JR to 0 with `pc_next_zero`=1 in EXEC1 → state 0, `active`=0, held for 20 cycles despite `waitrequest` and `muldiv_start` toggling.
- MAX_EXEC=4 build, exec_len=7 and exec_len=0 → clamped to 4 exec stages (states 3..6) and to 1 exec stage respectively; reset asserted mid-DIV in state 5 → immediate state=1, busy=0.
